// File: rtl/lock_sequencer.sv
// lock_sequencer: automatic operator for the canal-lock controller.
// One boatReq walks one boat through the full transit. The sequencer
// first matches the arrival level, then cycles the arrival gate around
// the boat's entry. It then matches the departure level and cycles the
// departure gate around the boat's exit. A shared timeout counter parks
// the sequencer in FAULT, and only reset leaves that state.
// Build option: define LOCK_SEQ_SETTLE_EN to add a settle hold of
// SETTLE_CYC cycles between level equality and the gate pulse.

module lock_sequencer #(
  parameter int GATE_TIMEOUT  = 16,
  parameter int LEVEL_TIMEOUT = 64,
  parameter int BOAT_TIMEOUT  = 255,
  parameter int CNT_W         = 8
`ifdef LOCK_SEQ_SETTLE_EN
  ,
  parameter int SETTLE_CYC    = 4
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       boatReq,
  input  logic [3:0] arrivOutsideLvl,
  input  logic [3:0] deptOutsideLvl,
  input  logic [3:0] insideWaterLvl,
  input  logic       arrivGate,
  input  logic       deptGate,
  input  logic       poundOccupied,
  output logic       incr,
  output logic       decr,
  output logic       gateCtrl,
  output logic       fiveMinTillArrival,
  output logic       busy,
  output logic       fault
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] FILL_ARR   = 4'd1;
  localparam logic [3:0] OPEN_ARR   = 4'd2;
  localparam logic [3:0] WAIT_IN    = 4'd3;
  localparam logic [3:0] CLOSE_ARR  = 4'd4;
  localparam logic [3:0] FILL_DEP   = 4'd5;
  localparam logic [3:0] OPEN_DEP   = 4'd6;
  localparam logic [3:0] WAIT_OUT   = 4'd7;
  localparam logic [3:0] CLOSE_DEP  = 4'd8;
  localparam logic [3:0] FAULT      = 4'd9;
`ifdef LOCK_SEQ_SETTLE_EN
  localparam logic [3:0] SETTLE_ARR = 4'd10;
  localparam logic [3:0] SETTLE_DEP = 4'd11;
`endif

  logic [3:0]       state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext, limit;
  logic [3:0]       target;
  logic             levelEq, levelLow, levelHigh, timedOut;
  logic             incrNext, decrNext, gateNext, fiveNext;

  // Pick the outside level the current fill phase has to match (tracked live, not latched).
  always_comb begin
    target = arrivOutsideLvl;
    if (state == FILL_DEP) target = deptOutsideLvl;
`ifdef LOCK_SEQ_SETTLE_EN
    if (state == SETTLE_DEP) target = deptOutsideLvl;
`endif
  end

  assign levelEq   = (insideWaterLvl == target);
  assign levelLow  = (insideWaterLvl <  target);
  assign levelHigh = (insideWaterLvl >  target);

  // Select the wait budget for the current state; the last allowed cycle is limit.
  always_comb begin
    limit = CNT_W'(GATE_TIMEOUT - 1);
    case (state)
      FILL_ARR, FILL_DEP: limit = CNT_W'(LEVEL_TIMEOUT - 1);
      WAIT_IN, WAIT_OUT:  limit = CNT_W'(BOAT_TIMEOUT - 1);
      default:            limit = CNT_W'(GATE_TIMEOUT - 1);
    endcase
  end

  assign timedOut = (cnt == limit);

  // Next-state and next-command decode; commands are registered together with the state.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    stateNext = state;
    cntNext   = cnt + 1'b1;
    incrNext  = 1'b0;
    decrNext  = 1'b0;
    gateNext  = 1'b0;
    fiveNext  = fiveMinTillArrival;
    case (state)
      IDLE: begin
        cntNext = '0;
        if (boatReq) begin
          stateNext = FILL_ARR;
          fiveNext  = 1'b1;
        end
      end
      FILL_ARR, FILL_DEP: begin
        if (levelEq) begin
`ifdef LOCK_SEQ_SETTLE_EN
          stateNext = (state == FILL_ARR) ? SETTLE_ARR : SETTLE_DEP;
`else
          stateNext = (state == FILL_ARR) ? OPEN_ARR : OPEN_DEP;
          gateNext  = 1'b1;
`endif
        end else if (timedOut) begin
          stateNext = FAULT;
        end else begin
          incrNext = levelLow;
          decrNext = levelHigh;
        end
      end
`ifdef LOCK_SEQ_SETTLE_EN
      SETTLE_ARR, SETTLE_DEP: begin
        if (!levelEq) begin
          stateNext = (state == SETTLE_ARR) ? FILL_ARR : FILL_DEP;
        end else if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          stateNext = (state == SETTLE_ARR) ? OPEN_ARR : OPEN_DEP;
          gateNext  = 1'b1;
        end
      end
`endif
      // Gate states ignore status during the pulse cycle, so a gate that was
      // already in position gets toggled away and then times out.
      OPEN_ARR: begin
        if (!gateCtrl && arrivGate) stateNext = WAIT_IN;
        else if (timedOut)          stateNext = FAULT;
      end
      WAIT_IN: begin
        if (poundOccupied) begin
          stateNext = CLOSE_ARR;
          gateNext  = 1'b1;
        end else if (timedOut) begin
          stateNext = FAULT;
        end
      end
      CLOSE_ARR: begin
        if (!gateCtrl && !arrivGate) begin
          stateNext = FILL_DEP;
          fiveNext  = 1'b0;
        end else if (timedOut) begin
          stateNext = FAULT;
        end
      end
      OPEN_DEP: begin
        if (!gateCtrl && deptGate) stateNext = WAIT_OUT;
        else if (timedOut)         stateNext = FAULT;
      end
      WAIT_OUT: begin
        if (!poundOccupied) begin
          stateNext = CLOSE_DEP;
          gateNext  = 1'b1;
        end else if (timedOut) begin
          stateNext = FAULT;
        end
      end
      CLOSE_DEP: begin
        if (!gateCtrl && !deptGate) stateNext = IDLE;
        else if (timedOut)          stateNext = FAULT;
      end
      FAULT: begin
        cntNext = cnt;
      end
      default: begin
        stateNext = IDLE;
        fiveNext  = 1'b0;
      end
    endcase
    if (stateNext == FAULT) begin
      incrNext = 1'b0;
      decrNext = 1'b0;
      gateNext = 1'b0;
      fiveNext = 1'b0;
    end
    if (stateNext != state) cntNext = '0;
  end

  // State, timeout counter and command registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      cnt                <= '0;
      incr               <= 1'b0;
      decr               <= 1'b0;
      gateCtrl           <= 1'b0;
      fiveMinTillArrival <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every register samples pre-edge values.
      state              <= stateNext;
      cnt                <= cntNext;
      incr               <= incrNext;
      decr               <= decrNext;
      gateCtrl           <= gateNext;
      fiveMinTillArrival <= fiveNext;
    end
  end

  assign busy  = (state != IDLE);
  assign fault = (state == FAULT);

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer. A simple lock model moves the
// water level one step per incr/decr cycle. It toggles the gates a few
// cycles after each gateCtrl pulse and moves the boat in or out while the
// matching gate is open. Expected values come from arithmetic on the
// requested levels.

module tb_lock_sequencer;

  localparam int GATE_TIMEOUT = 16;
`ifdef LOCK_SEQ_SETTLE_EN
  localparam int SETTLE_EXTRA = 4;
`else
  localparam int SETTLE_EXTRA = 0;
`endif

  typedef struct {
    logic [3:0] startLvl;
    logic [3:0] arrLvl;
    logic [3:0] depLvl;
    int         gateDly;
    int         boatDly;
    bit         spam;
    int         expIncr;
    int         expDecr;
    int         expFirst;
  } TransitVec;

  logic       clock, reset, boatReq;
  logic [3:0] arrivOutsideLvl, deptOutsideLvl, insideWaterLvl;
  logic       arrivGate, deptGate, poundOccupied;
  logic       incr, decr, gateCtrl, fiveMinTillArrival, busy, fault;

  logic [3:0] lvlReg, lvlLoadVal;
  bit         modelInit, gateStuck, gateSel;
  int         gateDelay, boatDelay, gateTimer, boatTimer;

  int errors = 0;
  int checks = 0;

  lock_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .boatReq            (boatReq),
    .arrivOutsideLvl    (arrivOutsideLvl),
    .deptOutsideLvl     (deptOutsideLvl),
    .insideWaterLvl     (insideWaterLvl),
    .arrivGate          (arrivGate),
    .deptGate           (deptGate),
    .poundOccupied      (poundOccupied),
    .incr               (incr),
    .decr               (decr),
    .gateCtrl           (gateCtrl),
    .fiveMinTillArrival (fiveMinTillArrival),
    .busy               (busy),
    .fault              (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Water moves during the cycle a command is held.
  assign insideWaterLvl = lvlReg + {3'b000, incr} - {3'b000, decr};

  // Lock model: level integration, delayed gate toggles, boat movement.
  always @(posedge clock) begin
    if (modelInit) begin
      lvlReg        <= lvlLoadVal;
      arrivGate     <= 1'b0;
      deptGate      <= 1'b0;
      poundOccupied <= 1'b0;
      gateTimer     <= 0;
      boatTimer     <= 0;
      gateSel       <= 1'b0;
    end else begin
      lvlReg <= insideWaterLvl;
      if (gateCtrl && !gateStuck) begin
        gateTimer <= gateDelay;
        gateSel   <= arrivGate || (!deptGate && !poundOccupied);
      end else if (gateTimer == 1) begin
        if (gateSel) arrivGate <= !arrivGate;
        else         deptGate  <= !deptGate;
        gateTimer <= 0;
      end else if (gateTimer > 1) begin
        gateTimer <= gateTimer - 1;
      end
      if ((arrivGate && !poundOccupied) || (deptGate && poundOccupied)) begin
        if (boatTimer >= boatDelay) begin
          poundOccupied <= !poundOccupied;
          boatTimer     <= 0;
        end else begin
          boatTimer <= boatTimer + 1;
        end
      end else begin
        boatTimer <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int posDiff(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  // Load the model, pulse boatReq; returns at the falling edge of cycle 1 after acceptance.
  task automatic acceptRequest(input logic [3:0] startLvl, input logic [3:0] arrLvl,
                               input logic [3:0] depLvl);
    @(negedge clock);
    modelInit       = 1'b1;
    lvlLoadVal      = startLvl;
    arrivOutsideLvl = arrLvl;
    deptOutsideLvl  = depLvl;
    @(negedge clock);
    modelInit = 1'b0;
    boatReq   = 1'b1;
    @(negedge clock);
    boatReq = 1'b0;
  endtask

  // Run one full transit and compare its observable totals with the expected ones.
  task automatic doTransit(input string tag, input logic [3:0] startLvl, input logic [3:0] arrLvl,
                           input logic [3:0] depLvl, input int gDly, input int bDly, input bit spam,
                           input int expIncr, input int expDecr, input int expFirst);
    int nIncr, nDecr, nPulse, firstPulse, nViol;
    bit finished, entered;
    nIncr = 0; nDecr = 0; nPulse = 0; firstPulse = -1; nViol = 0;
    finished = 1'b0; entered = 1'b0;
    gateDelay = gDly;
    boatDelay = bDly;
    acceptRequest(startLvl, arrLvl, depLvl);
    for (int k = 1; k <= 600; k++) begin
      if (incr) nIncr++;
      if (decr) nDecr++;
      if (gateCtrl) begin
        nPulse++;
        if (firstPulse < 0) firstPulse = k;
      end
      if (incr && decr) nViol++;
      if (gateCtrl && (incr || decr)) nViol++;
      if (fault) nViol++;
      if (poundOccupied) entered = 1'b1;
      if (busy && !entered && !fiveMinTillArrival) nViol++;
      if (!busy) begin
        finished = 1'b1;
        if (fiveMinTillArrival) nViol++;
        break;
      end
      boatReq = spam && ($urandom_range(0, 3) == 0);
      @(negedge clock);
    end
    boatReq = 1'b0;
    check({tag, " finished"}, finished, 1);
    check({tag, " incr cycles"}, nIncr, expIncr);
    check({tag, " decr cycles"}, nDecr, expDecr);
    check({tag, " gate pulses"}, nPulse, 4);
    check({tag, " first pulse cycle"}, firstPulse, expFirst);
    check({tag, " rule violations"}, nViol, 0);
    check({tag, " final level"}, insideWaterLvl, depLvl);
    repeat (3) @(negedge clock);
    check({tag, " idle after transit"}, {busy, fault}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TransitVec vecs [5];
    int pulseAt, faultAt, lateCmds;
    logic [3:0] s, a, d;

    vecs[0] = '{startLvl: 4'd0,  arrLvl: 4'd4, depLvl: 4'd0,  gateDly: 2, boatDly: 3, spam: 1'b0,
                expIncr: 4,  expDecr: 4,  expFirst: 6};
    vecs[1] = '{startLvl: 4'd7,  arrLvl: 4'd7, depLvl: 4'd7,  gateDly: 1, boatDly: 0, spam: 1'b1,
                expIncr: 0,  expDecr: 0,  expFirst: 2};
    vecs[2] = '{startLvl: 4'd15, arrLvl: 4'd0, depLvl: 4'd15, gateDly: 3, boatDly: 5, spam: 1'b0,
                expIncr: 15, expDecr: 15, expFirst: 17};
    vecs[3] = '{startLvl: 4'd3,  arrLvl: 4'd9, depLvl: 4'd2,  gateDly: 1, boatDly: 2, spam: 1'b1,
                expIncr: 6,  expDecr: 7,  expFirst: 8};
    vecs[4] = '{startLvl: 4'd10, arrLvl: 4'd8, depLvl: 4'd12, gateDly: 5, boatDly: 1, spam: 1'b0,
                expIncr: 4,  expDecr: 2,  expFirst: 4};

    reset = 1'b0; boatReq = 1'b0; modelInit = 1'b1; gateStuck = 1'b0;
    lvlLoadVal = 4'd0; arrivOutsideLvl = 4'd0; deptOutsideLvl = 4'd0;
    gateDelay = 1; boatDelay = 1;
    repeat (3) @(negedge clock);
    check("reset outputs", {incr, decr, gateCtrl, fiveMinTillArrival, busy, fault}, 0);
    reset = 1'b1;
    modelInit = 1'b0;

    // Reset asserted mid-fill while incr is high.
    acceptRequest(4'd0, 4'd10, 4'd10);
    repeat (2) @(negedge clock);
    check("incr before reset", incr, 1);
    reset = 1'b0;
    #1;
    check("outputs during reset", {incr, decr, gateCtrl, fiveMinTillArrival, busy, fault}, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle after reset release", {busy, fault, incr}, 0);

    for (int i = 0; i < 5; i++) begin
      doTransit($sformatf("vec%0d", i), vecs[i].startLvl, vecs[i].arrLvl, vecs[i].depLvl,
                vecs[i].gateDly, vecs[i].boatDly, vecs[i].spam,
                vecs[i].expIncr, vecs[i].expDecr, vecs[i].expFirst + SETTLE_EXTRA);
    end

    // Arrival gate never moves: fault GATE_TIMEOUT cycles after the pulse.
    gateStuck = 1'b1;
    acceptRequest(4'd5, 4'd5, 4'd5);
    pulseAt = -1; faultAt = -1;
    for (int k = 1; k <= 100; k++) begin
      if (gateCtrl && pulseAt < 0) pulseAt = k;
      if (fault) begin
        faultAt = k;
        break;
      end
      @(negedge clock);
    end
    check("stuck pulse cycle", pulseAt, 2 + SETTLE_EXTRA);
    check("stuck fault delay", faultAt - pulseAt, GATE_TIMEOUT);
    check("fault commands", {incr, decr, gateCtrl, fiveMinTillArrival}, 0);
    check("fault busy", busy, 1);
    boatReq = 1'b1;
    @(negedge clock);
    boatReq = 1'b0;
    lateCmds = 0;
    repeat (20) begin
      if (gateCtrl || incr || decr || fiveMinTillArrival || !fault) lateCmds++;
      @(negedge clock);
    end
    check("fault holds, request ignored", lateCmds, 0);
    reset = 1'b0;
    #1;
    check("fault cleared by reset", {fault, busy}, 0);
    @(negedge clock);
    reset = 1'b1;
    gateStuck = 1'b0;

`ifdef LOCK_SEQ_SETTLE_EN
    // Arrival target moves during the settle hold.
    begin
      int incrAfter, settlePulse;
      bit done;
      incrAfter = 0; settlePulse = -1; done = 1'b0;
      gateDelay = 1; boatDelay = 1;
      acceptRequest(4'd0, 4'd4, 4'd4);
      for (int k = 1; k <= 300; k++) begin
        if (k == 7) arrivOutsideLvl = 4'd5;
        if (k >= 8 && settlePulse < 0 && incr) incrAfter++;
        if (gateCtrl && settlePulse < 0) settlePulse = k;
        if (!busy) begin
          done = 1'b1;
          break;
        end
        @(negedge clock);
      end
      check("settle re-fill incr cycles", incrAfter, 1);
      check("settle pulse cycle", settlePulse, 14);
      check("settle transit finished", {done, fault}, 2);
    end
`endif

    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom_range(0, 15));
      a = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      doTransit($sformatf("rnd%0d", i), s, a, d,
                $urandom_range(1, 8), $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                posDiff(a, s) + posDiff(d, a), posDiff(s, a) + posDiff(a, d),
                posDiff(a, s) + posDiff(s, a) + 2 + SETTLE_EXTRA);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
Name: lock_sequencer

Overview:
- Automatic operator for the canal-lock controller. It drives the lock's command inputs (incr, decr, gateCtrl, fiveMinTillArrival) from the lock's status outputs (arrivGate, deptGate, insideWaterLvl, poundOccupied).
- It replaces the manual operator and sits between the boat-traffic request logic and the lock.
- One request walks one boat through the full sequence:
  - match the arrival level, open the arrival gate, admit the boat, close the gate;
  - match the departure level, open the departure gate, release the boat, close the gate.

Parameters:
- GATE_TIMEOUT, 16: cycles allowed for a gate status to change after a gateCtrl pulse.
- LEVEL_TIMEOUT, 64: cycles allowed for insideWaterLvl to reach its target.
- BOAT_TIMEOUT, 255: cycles allowed for poundOccupied to change while a gate is open.
- CNT_W, 8: width of the shared timeout counter. It must hold the largest timeout.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- boatReq  input  1  one-cycle pulse requesting a transit. Ignored unless the state is IDLE.
- arrivOutsideLvl  input  4  water level outside the arrival gate.
- deptOutsideLvl  input  4  water level outside the departure gate.
- insideWaterLvl  input  4  pound level reported by the lock.
- arrivGate  input  1  1 = arrival gate open.
- deptGate  input  1  1 = departure gate open.
- poundOccupied  input  1  1 = boat inside the pound.
- incr  output  1  raise the pound level; held while below target.
- decr  output  1  lower the pound level; held while above target.
- gateCtrl  output  1  one-cycle gate-toggle pulse.
- fiveMinTillArrival  output  1  1 from request acceptance until the arrival gate closes.
- busy  output  1  1 in any state other than IDLE.
- fault  output  1  sticky; set on any timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; counter = 0.
  - All outputs = 0.
- Release of reset is a synchronous deassertion.
- States:
  - IDLE: boatReq=1 -> FILL_ARR. fiveMinTillArrival is set to 1 on the same edge.
  - FILL_ARR: target = arrivOutsideLvl.
    - incr = (insideWaterLvl < target); decr = (insideWaterLvl > target).
    - This comparison is registered, so the outputs lag the level by one cycle.
    - Equality seen -> OPEN_ARR, with incr and decr 0 on that edge.
  - OPEN_ARR: gateCtrl=1 for exactly one cycle, then wait for arrivGate=1 -> WAIT_IN.
  - WAIT_IN: wait for poundOccupied=1 -> CLOSE_ARR.
  - CLOSE_ARR: one gateCtrl pulse, then wait for arrivGate=0 -> FILL_DEP. fiveMinTillArrival clears on entry to FILL_DEP.
  - FILL_DEP: same rule as FILL_ARR with target = deptOutsideLvl; on equality -> OPEN_DEP.
  - OPEN_DEP: one gateCtrl pulse, then wait for deptGate=1 -> WAIT_OUT.
  - WAIT_OUT: wait for poundOccupied=0 -> CLOSE_DEP.
  - CLOSE_DEP: one gateCtrl pulse, then wait for deptGate=0 -> IDLE.
  - FAULT: all command outputs are 0; fault=1; busy=1. Exit only by reset.
- Target levels are sampled every cycle, not latched. A changing outside level is tracked.
- incr and decr are never both 1.
- gateCtrl is never issued while incr or decr is 1. Before any gate pulse, the level must be equal for at least 1 cycle.
- Timeout counter:
  - Cleared on every state entry; increments each cycle while waiting.
  - GATE_TIMEOUT applies in OPEN/CLOSE states, LEVEL_TIMEOUT in FILL states, BOAT_TIMEOUT in WAIT states.
  - Counter reaching its limit -> FAULT on the next edge.
- Boundary cases:
  - Level already equal on entry to FILL_x: no incr/decr cycle; OPEN on the next edge.
  - Gate already in the target position at OPEN/CLOSE entry: the pulse is still issued, then the wait applies. The resulting mismatch times out into FAULT; this is intended and signals a desynchronised lock.
  - boatReq during busy: ignored, with no queuing.
  - reset low mid-sequence: immediate return to IDLE with outputs 0. Gate and level state in the lock are not restored.
  - incr or decr requested at level 15 or 0: no saturation handling is needed here. The comparison cannot request beyond 4-bit range because targets are 4 bits.

Optional Feature:
- Macro: LOCK_SEQ_SETTLE_EN.
- Defined: after level equality in FILL_ARR or FILL_DEP, a SETTLE state holds all commands at 0 for SETTLE_CYC cycles before the OPEN state.
  - SETTLE_CYC is an extra parameter, default 4.
  - A level change during SETTLE returns to the FILL state, with the counter cleared.
- Undefined: no SETTLE state and no SETTLE_CYC parameter; FILL goes directly to OPEN.

Test Plan:
1. Reset low mid-FILL_ARR with incr=1 -> same cycle incr=0, busy=0, fault=0; after release the state is IDLE.
2. Lock model at level 0, arrivOutsideLvl=4, deptOutsideLvl=0, boatReq pulse:
   - Expect fiveMinTillArrival=1 and incr high for 4 cycles, then one gateCtrl pulse.
   - Model opens the arrival gate; boat enters; expect a second gateCtrl pulse.
   - Then decr high for 4 cycles, gateCtrl, boat leaves, gateCtrl, busy=0 and fault=0.
3. arrivOutsideLvl equal to insideWaterLvl=7 at request -> no incr or decr asserted; gateCtrl on the 2nd cycle after acceptance.
4. Model never raises arrivGate after the pulse -> fault=1 exactly GATE_TIMEOUT=16 cycles after the gateCtrl pulse; all outputs 0; a later boatReq is ignored until reset.
5. boatReq pulses while busy=1 -> no effect on the sequence; after return to IDLE, a new boatReq starts a fresh transit.
6. With LOCK_SEQ_SETTLE_EN defined, SETTLE_CYC=4:
   - Gate pulse occurs 4 cycles later than in scenario 2.
   - Changing arrivOutsideLvl from 4 to 5 during SETTLE -> incr reasserts for 1 cycle before re-settling.
